wave_pattern_gen: RTL and testbench



---
 rtl/wave_pattern_gen.sv | 174 +++++++++++++++++
 tb/tb_wave_pattern_gen.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/wave_pattern_gen.sv
// Stepped triangle/sawtooth/square sample generator standing in for the ADC on the measurement datapath.
// First sample one edge after EN is seen in IDLE; no backpressure, each sample lasts max(HOLD,1) cycles.
module wave_pattern_gen #(
  parameter int HOLD_W  = 16,
  parameter int NSTEP_W = 8
) (
  input  logic               CLK,
  input  logic               RSTB,
  input  logic               EN,
  input  logic [1:0]         MODE,
  input  logic [11:0]        BASE,
  input  logic [11:0]        STEP,
  input  logic [NSTEP_W-1:0] NSTEPS,
  input  logic [HOLD_W-1:0]  HOLD,
  output logic [11:0]        DATA_OUT,
  output logic               DATA_VALID,
  output logic               PERIOD_START,
  output logic [15:0]        PERIOD_CNT,
  output logic               BUSY
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_UP   = 2'd1;
  localparam logic [1:0] S_DOWN = 2'd2;

  localparam logic [1:0] M_SAW = 2'd1;
  localparam logic [1:0] M_SQR = 2'd2;

  localparam int SUM_W = 12 + NSTEP_W + 1;

  logic [1:0]         state;
  logic [NSTEP_W-1:0] k;
  logic [HOLD_W-1:0]  hold_cnt;

  logic [1:0]         sh_mode;
  logic [11:0]        sh_base;
  logic [11:0]        sh_step;
  logic [NSTEP_W-1:0] sh_nsteps;
  logic [HOLD_W-1:0]  sh_hold;

  logic [1:0]         nxt_state;
  logic [NSTEP_W-1:0] nxt_k;
  logic               nxt_ps;
  logic [NSTEP_W-1:0] sample_idx;
  logic [SUM_W-1:0]   sum;
  logic [11:0]        sample;
  logic [HOLD_W-1:0]  hold_max;
  logic               hold_done;

  assign hold_max  = (sh_hold == '0) ? HOLD_W'(1) : sh_hold;
  assign hold_done = (hold_cnt >= hold_max);

  // Next step position; nxt_ps marks the first sample of a new period.
  always_comb begin
    nxt_state = state;
    nxt_k     = k;
    nxt_ps    = 1'b0;
    if (sh_nsteps == '0) begin
      nxt_state = S_UP;
      nxt_k     = '0;
      nxt_ps    = 1'b1;
    end else begin
      case (sh_mode)
        M_SAW: begin
          if (k == sh_nsteps) begin
            nxt_k  = '0;
            nxt_ps = 1'b1;
          end else begin
            nxt_k = k + NSTEP_W'(1);
          end
        end
        M_SQR: begin
          // k counts steps within the current half-period here
          if (k == sh_nsteps - NSTEP_W'(1)) begin
            nxt_k = '0;
            if (state == S_UP) begin
              nxt_state = S_DOWN;
            end else begin
              nxt_state = S_UP;
              nxt_ps    = 1'b1;
            end
          end else begin
            nxt_k = k + NSTEP_W'(1);
          end
        end
        default: begin
          if (state == S_UP) begin
            if (k != sh_nsteps) begin
              nxt_k = k + NSTEP_W'(1);
            end else if (sh_nsteps == NSTEP_W'(1)) begin
              nxt_k  = '0;
              nxt_ps = 1'b1;
            end else begin
              nxt_state = S_DOWN;
              nxt_k     = sh_nsteps - NSTEP_W'(1);
            end
          end else begin
            if (k == NSTEP_W'(1)) begin
              nxt_state = S_UP;
              nxt_k     = '0;
              nxt_ps    = 1'b1;
            end else begin
              nxt_k = k - NSTEP_W'(1);
            end
          end
        end
      endcase
    end
  end

  always_comb begin
    sample_idx = nxt_k;
    if (sh_mode == M_SQR) begin
      sample_idx = (nxt_state == S_DOWN) ? sh_nsteps : '0;
    end
    sum    = SUM_W'(sh_base) + SUM_W'(sample_idx) * SUM_W'(sh_step);
    sample = (|sum[SUM_W-1:12]) ? 12'hFFF : sum[11:0];
  end

  always_ff @(posedge CLK or negedge RSTB) begin
    if (!RSTB) begin
      state        <= S_IDLE;
      k            <= '0;
      hold_cnt     <= '0;
      sh_mode      <= '0;
      sh_base      <= '0;
      sh_step      <= '0;
      sh_nsteps    <= '0;
      sh_hold      <= '0;
      DATA_OUT     <= '0;
      DATA_VALID   <= 1'b0;
      PERIOD_START <= 1'b0;
      PERIOD_CNT   <= '0;
      BUSY         <= 1'b0;
    end else if (state == S_IDLE) begin
      DATA_VALID   <= 1'b0;
      PERIOD_START <= 1'b0;
      if (EN) begin
        sh_mode      <= MODE;
        sh_base      <= BASE;
        sh_step      <= STEP;
        sh_nsteps    <= NSTEPS;
        sh_hold      <= HOLD;
        DATA_OUT     <= BASE;
        DATA_VALID   <= 1'b1;
        PERIOD_START <= 1'b1;
        k            <= '0;
        hold_cnt     <= HOLD_W'(1);
        state        <= S_UP;
        BUSY         <= 1'b1;
      end
    end else if (!EN) begin
      state        <= S_IDLE;
      BUSY         <= 1'b0;
      DATA_VALID   <= 1'b0;
      PERIOD_START <= 1'b0;
    end else if (hold_done) begin
      state        <= nxt_state;
      k            <= nxt_k;
      DATA_OUT     <= sample;
      DATA_VALID   <= 1'b1;
      PERIOD_START <= nxt_ps;
      hold_cnt     <= HOLD_W'(1);
      if (nxt_ps) begin
        PERIOD_CNT <= PERIOD_CNT + 16'd1;
      end
    end else begin
      hold_cnt     <= hold_cnt + HOLD_W'(1);
      DATA_VALID   <= 1'b0;
      PERIOD_START <= 1'b0;
    end
  end

endmodule

// File: tb/tb_wave_pattern_gen.sv
// Scoreboard bench: stimulus queues expected samples, a negedge monitor checks each DATA_VALID sample.
module tb_wave_pattern_gen;

  logic        CLK;
  logic        RSTB;
  logic        EN;
  logic [1:0]  MODE;
  logic [11:0] BASE;
  logic [11:0] STEP;
  logic [7:0]  NSTEPS;
  logic [15:0] HOLD;
  logic [11:0] DATA_OUT;
  logic        DATA_VALID;
  logic        PERIOD_START;
  logic [15:0] PERIOD_CNT;
  logic        BUSY;

  wave_pattern_gen #(.HOLD_W(16), .NSTEP_W(8)) dut (
    .CLK(CLK), .RSTB(RSTB), .EN(EN), .MODE(MODE), .BASE(BASE), .STEP(STEP),
    .NSTEPS(NSTEPS), .HOLD(HOLD), .DATA_OUT(DATA_OUT), .DATA_VALID(DATA_VALID),
    .PERIOD_START(PERIOD_START), .PERIOD_CNT(PERIOD_CNT), .BUSY(BUSY)
  );

  typedef struct {
    int data;
    int ps;
    int cnt;
    int gap;
  } exp_t;

  exp_t sb[$];
  int n_chk = 0;
  int n_fail = 0;

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic push(input int data, input int ps, input int cnt, input int gap);
    exp_t e;
    e.data = data; e.ps = ps; e.cnt = cnt; e.gap = gap;
    sb.push_back(e);
  endtask

  task automatic wait_empty(input int budget);
    int n;
    n = 0;
    while (sb.size() != 0 && n < budget) begin
      @(negedge CLK);
      #1;
      n++;
    end
    if (sb.size() != 0) begin
      chk("wait_empty_timeout_left", sb.size(), 0);
      sb.delete();
    end
  endtask

  task automatic start(input int m, input int b, input int s, input int n, input int h);
    MODE = 2'(m); BASE = 12'(b); STEP = 12'(s); NSTEPS = 8'(n); HOLD = 16'(h);
    EN = 1'b1;
  endtask

  task automatic stop_and_check();
    EN = 1'b0;
    @(negedge CLK);
    @(negedge CLK);
    chk("stop_busy", BUSY, 0);
    chk("stop_valid", DATA_VALID, 0);
  endtask

  // Monitor: every DATA_VALID must match the head of the scoreboard.
  initial begin
    exp_t e;
    int since;
    since = 0;
    forever begin
      @(negedge CLK);
      since++;
      if (DATA_VALID === 1'b1) begin
        if (sb.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL unexpected_sample: got %0d expected none at %0t", DATA_OUT, $time);
        end else begin
          e = sb.pop_front();
          chk("data_out", int'(DATA_OUT), e.data);
          chk("period_start", int'(PERIOD_START), e.ps);
          chk("period_cnt", int'(PERIOD_CNT), e.cnt);
          if (e.gap != 0) chk("sample_spacing", since, e.gap);
        end
        since = 0;
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int tri_tab[12] = '{1000, 1002, 1004, 1006, 1008, 1010, 1012, 1010, 1008, 1006, 1004, 1002};
    int saw_tab[6]  = '{0, 1000, 2000, 3000, 4000, 4095};

    RSTB = 1'b0; EN = 1'b0; MODE = '0; BASE = '0; STEP = '0; NSTEPS = '0; HOLD = '0;
    #12;
    chk("reset_data", DATA_OUT, 0);
    chk("reset_valid", DATA_VALID, 0);
    chk("reset_pstart", PERIOD_START, 0);
    chk("reset_pcnt", PERIOD_CNT, 0);
    chk("reset_busy", BUSY, 0);
    @(negedge CLK);
    #1 RSTB = 1'b1;
    @(negedge CLK);

    // Triangle, 12-step period at 10 cycles per step; stop mid-step at 1006.
    for (int i = 0; i < 40; i++) push(tri_tab[i % 12], (i % 12 == 0) ? 1 : 0, i / 12, (i == 0) ? 0 : 10);
    start(0, 1000, 2, 6, 10);
    wait_empty(600);
    repeat (4) @(negedge CLK);
    EN = 1'b0;
    @(negedge CLK);
    @(negedge CLK);
    chk("stop_busy", BUSY, 0);
    chk("stop_hold_data", DATA_OUT, 1006);
    chk("stop_valid", DATA_VALID, 0);
    chk("stop_pstart", PERIOD_START, 0);
    chk("stop_pcnt", PERIOD_CNT, 3);
    push(500, 1, 3, 0);
    start(0, 500, 2, 6, 10);
    wait_empty(20);
    stop_and_check();

    // Sawtooth with saturation; config changes while busy must be ignored.
    for (int i = 0; i < 13; i++) push(saw_tab[i % 6], (i % 6 == 0) ? 1 : 0, 3 + i / 6, (i == 0) ? 0 : 1);
    start(1, 0, 1000, 5, 1);
    @(negedge CLK);
    @(negedge CLK);
    BASE = 12'd999; STEP = 12'd1; NSTEPS = 8'd2;
    wait_empty(40);
    stop_and_check();

    // Square: four BASE samples then four peak samples, 3 cycles each.
    for (int i = 0; i < 17; i++) push(((i % 8) < 4) ? 100 : 300, (i % 8 == 0) ? 1 : 0, 5 + i / 8, (i == 0) ? 0 : 3);
    start(2, 100, 50, 4, 3);
    wait_empty(80);
    stop_and_check();

    // NSTEPS=0, HOLD=0: every cycle is a full one-step period.
    for (int i = 0; i < 6; i++) push(77, 1, 7 + i, (i == 0) ? 0 : 1);
    start(0, 77, 9, 0, 0);
    wait_empty(20);
    stop_and_check();

    // Reserved mode behaves as triangle; NSTEPS=1 gives a two-step period.
    push(10, 1, 12, 0); push(15, 0, 12, 2); push(10, 1, 13, 2); push(15, 0, 13, 2); push(10, 1, 14, 2);
    start(3, 10, 5, 1, 2);
    wait_empty(30);
    stop_and_check();

    // Asynchronous reset mid-step, then restart with EN held high.
    push(200, 1, 14, 0); push(203, 0, 14, 10);
    start(0, 200, 3, 2, 10);
    wait_empty(40);
    repeat (3) @(negedge CLK);
    #2 RSTB = 1'b0;
    #1;
    chk("arst_data", DATA_OUT, 0);
    chk("arst_busy", BUSY, 0);
    chk("arst_pcnt", PERIOD_CNT, 0);
    chk("arst_valid", DATA_VALID, 0);
    push(200, 1, 0, 0);
    @(negedge CLK);
    #1 RSTB = 1'b1;
    wait_empty(10);
    stop_and_check();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
